// File: rtl/cpu_pkg.sv
// Shared CPU definitions: R-type opcode/funct constants, the abstract ALU
// op encoding (same code as ALUOp) and the instruction loader state enum.
package cpu_pkg;

   localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
   localparam logic [5:0] FUNCT_ADD    = 6'b100000;
   localparam logic [5:0] FUNCT_SUB    = 6'b100010;
   localparam logic [5:0] FUNCT_AND    = 6'b100100;
   localparam logic [5:0] FUNCT_SLL    = 6'b000000;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_ADD = 2'b01,
      OP_SUB = 2'b10,
      OP_AND = 2'b11
   } op_kind_t;

   // WRITE/READ/CHECK are only reached when read-back verification is built in.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_WRITE = 3'd4,
      ST_READ  = 3'd5,
      ST_CHECK = 3'd6
   } loader_state_t;

endpackage

// File: rtl/r_type_enc.sv
// Combinational encoder: abstract ALU op + register fields -> 32-bit MIPS
// R-type word. NOP encodes to all zeros regardless of the register fields.
module r_type_enc
   import cpu_pkg::*;
(
   input  logic [1:0]  i_kind,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   output logic [31:0] o_word
);

   op_kind_t   w_kind;
   logic [5:0] w_funct;

   assign w_kind = op_kind_t'(i_kind);

   // Select the funct field for the requested ALU operation.
   always_comb begin
      w_funct = FUNCT_SLL;
      case (w_kind)
         OP_ADD:  w_funct = FUNCT_ADD;
         OP_SUB:  w_funct = FUNCT_SUB;
         OP_AND:  w_funct = FUNCT_AND;
         default: w_funct = FUNCT_SLL;
      endcase
   end

   assign o_word = (w_kind == OP_NOP) ? 32'h0000_0000
                                      : {OPCODE_RTYPE, i_rs, i_rt, i_rd, 5'b00000, w_funct};

endmodule

// File: rtl/instr_loader_encoder.sv
// Instruction memory loader: accepts abstract ALU ops over a valid/ready
// handshake, encodes each to an R-type word and writes it to imem at
// consecutive word addresses starting from 0.
// Optional build macro LOADER_READBACK_EN adds a write/read/compare pass
// per word (imem_re, imem_rdata, mismatch).
//
// Handshake: an op transfers on a rising edge where op_valid && op_ready.
// op_ready depends on FSM state only (never on op_valid); op_valid is a
// don't-care while op_ready is low. The write appears one cycle after accept.
module instr_loader_encoder
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [1:0]        op_kind,
   input  logic [4:0]        op_rs,
   input  logic [4:0]        op_rt,
   input  logic [4:0]        op_rd,
   input  logic              op_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              full,
   output logic [ADDR_W:0]   word_count,
`ifdef LOADER_READBACK_EN
   output logic              imem_re,
   input  logic [31:0]       imem_rdata,
   output logic              mismatch,
`endif
   output logic [2:0]        dbg_state
);

   loader_state_t     r_state;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_done;
   logic [31:0]       w_enc;
   logic              w_accept;
   logic              w_at_cap;
   logic              w_final;
`ifdef LOADER_READBACK_EN
   logic              r_re;
   logic              r_final;
   logic              r_mismatch;
`endif

   r_type_enc u_enc (
      .i_kind (op_kind),
      .i_rs   (op_rs),
      .i_rt   (op_rt),
      .i_rd   (op_rd),
      .o_word (w_enc)
   );

`ifdef LOADER_READBACK_EN
   // The CHECK cycle also offers the next op, so ready is low for exactly the
   // WRITE and READ cycles between accepts: one op every three cycles.
   assign op_ready = (r_state == ST_LOAD) || ((r_state == ST_CHECK) && !r_final);
`else
   assign op_ready = (r_state == ST_LOAD);
`endif

   assign w_accept = op_valid && op_ready;
   // The op being accepted lands on the top address of imem.
   assign w_at_cap = (r_count == {1'b0, {ADDR_W{1'b1}}});
   assign w_final  = op_last || w_at_cap;

   // Loader FSM with registered write port, address, count and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_done  <= 1'b0;
`ifdef LOADER_READBACK_EN
         r_re       <= 1'b0;
         r_final    <= 1'b0;
         r_mismatch <= 1'b0;
`endif
      end else begin
         r_we <= 1'b0;
`ifdef LOADER_READBACK_EN
         r_re <= 1'b0;
         if ((r_state == ST_CHECK) && (imem_rdata != r_wdata))
            r_mismatch <= 1'b1;
`endif
         if (w_accept) begin
            r_we    <= 1'b1;
            r_addr  <= r_count[ADDR_W-1:0];
            r_wdata <= w_enc;
            r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
            if (w_final)
               r_full <= !op_last;
`ifdef LOADER_READBACK_EN
            r_final <= w_final;
            r_state <= ST_WRITE;
`else
            r_state <= w_final ? ST_DRAIN : ST_LOAD;
`endif
         end else begin
            case (r_state)
               ST_IDLE, ST_DONE: begin
                  if (start) begin
                     r_state <= ST_LOAD;
                     r_addr  <= '0;
                     r_count <= '0;
                     r_full  <= 1'b0;
                     r_done  <= 1'b0;
`ifdef LOADER_READBACK_EN
                     r_final    <= 1'b0;
                     r_mismatch <= 1'b0;
`endif
                  end
               end
               ST_DRAIN: begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
`ifdef LOADER_READBACK_EN
               ST_WRITE: begin
                  r_state <= ST_READ;
                  r_re    <= 1'b1;
               end
               ST_READ: r_state <= ST_CHECK;
               ST_CHECK: begin
                  if (r_final) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_LOAD;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign word_count = r_count;
   assign full       = r_full;
   assign done       = r_done;
   assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign dbg_state  = r_state;
`ifdef LOADER_READBACK_EN
   assign imem_re    = r_re;
   assign mismatch   = r_mismatch;
`endif

endmodule

// File: tb/tb_instr_loader_encoder.sv
// Directed bench for instr_loader_encoder. Two instances share the op
// stream: u0 with the default 256-word imem, u1 with a 4-word imem for the
// capacity case. Writes are logged at the falling edge and compared against
// hand-computed expected words.
module tb_instr_loader_encoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       op_valid = 1'b0;
   logic [1:0] op_kind = 2'b00;
   logic [4:0] op_rs = 5'd0;
   logic [4:0] op_rt = 5'd0;
   logic [4:0] op_rd = 5'd0;
   logic       op_last = 1'b0;

   logic        a_ready, a_we, a_busy, a_done, a_full;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_count;
   logic [2:0]  a_state;

   logic        b_ready, b_we, b_busy, b_done, b_full;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_count;
   logic [2:0]  b_state;

`ifdef LOADER_READBACK_EN
   logic        a_re, a_mis, b_re, b_mis;
   logic [31:0] a_rdata = 32'h0;
   logic [31:0] b_rdata = 32'h0;
   logic [31:0] a_mem [256];
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [39:0] a_got [$];
   logic [39:0] b_got [$];
   int          a_cyc [$];
   int          a_acc [$];
   logic [39:0] exp_q [$];

   instr_loader_encoder #(.ADDR_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_ready(a_ready),
      .op_kind(op_kind), .op_rs(op_rs), .op_rt(op_rt), .op_rd(op_rd), .op_last(op_last),
      .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .busy(a_busy),
      .done(a_done), .full(a_full), .word_count(a_count),
`ifdef LOADER_READBACK_EN
      .imem_re(a_re), .imem_rdata(a_rdata), .mismatch(a_mis),
`endif
      .dbg_state(a_state)
   );

   instr_loader_encoder #(.ADDR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_ready(b_ready),
      .op_kind(op_kind), .op_rs(op_rs), .op_rt(op_rt), .op_rd(op_rd), .op_last(op_last),
      .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .busy(b_busy),
      .done(b_done), .full(b_full), .word_count(b_count),
`ifdef LOADER_READBACK_EN
      .imem_re(b_re), .imem_rdata(b_rdata), .mismatch(b_mis),
`endif
      .dbg_state(b_state)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef LOADER_READBACK_EN
   // imem model for u0 corrupts the word at address 1 on read; u1 echoes its write
   always @(posedge clk) begin
      if (a_we) a_mem[a_addr] <= a_wdata;
      if (a_re) a_rdata <= (a_addr == 8'd1) ? (a_mem[a_addr] ^ 32'h0000_0001) : a_mem[a_addr];
      if (b_re) b_rdata <= b_wdata;
   end
`endif

   // write / accept log
   always @(negedge clk) begin
      if (a_we) begin
         a_got.push_back({a_addr, a_wdata});
         a_cyc.push_back(cyc);
      end
      if (b_we) b_got.push_back({6'b0, b_addr, b_wdata});
      if (op_valid && a_ready) a_acc.push_back(cyc);
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_op(input int sel, input logic [1:0] k, input logic [4:0] s,
                          input logic [4:0] t, input logic [4:0] d, input logic l);
      bit got;
      got = 1'b0;
      op_kind = k; op_rs = s; op_rt = t; op_rd = d; op_last = l; op_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((sel == 0) ? a_ready : b_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL send_op_accept got=0 want=1 (sel %0d)", sel);
      end
   endtask

   task automatic wait_done(input int sel, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((sel == 0) ? a_done : b_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_ready, a_we, a_busy, a_done, a_full} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b want=00000", {a_ready, a_we, a_busy, a_done, a_full});
      end
      checks++;
      if (a_addr !== 8'h0 || a_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus got=%h/%h want=00/00000000", a_addr, a_wdata);
      end
      checks++;
      if (a_count !== 9'd0 || a_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_count_state got=%0d/%0d want=0/0", a_count, a_state);
      end
`ifdef LOADER_READBACK_EN
      checks++;
      if ({a_re, a_mis} !== 2'b00) begin
         errors++;
         $display("FAIL reset_readback got=%b want=00", {a_re, a_mis});
      end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // start and op_valid together in IDLE: op waits, then ADD 1,2,3 last
   task automatic test_add();
      bit ok;
      a_got.delete();
      op_kind = 2'b01; op_rs = 5'd1; op_rt = 5'd2; op_rd = 5'd3; op_last = 1'b1;
      op_valid = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (a_we !== 1'b0 || a_ready !== 1'b1 || a_state !== 3'd1) begin
         errors++;
         $display("FAIL add_start_no_accept got we=%b rdy=%b st=%0d want we=0 rdy=1 st=1",
                  a_we, a_ready, a_state);
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (a_we !== 1'b1 || a_addr !== 8'd0 || a_wdata !== 32'h0022_1820) begin
         errors++;
         $display("FAIL add_write got we=%b addr=%h data=%h want we=1 addr=00 data=00221820",
                  a_we, a_addr, a_wdata);
      end
`ifndef LOADER_READBACK_EN
      @(negedge clk);
      checks++;
      if (a_done !== 1'b1 || a_we !== 1'b0) begin
         errors++;
         $display("FAIL add_done_next got done=%b we=%b want done=1 we=0", a_done, a_we);
      end
`endif
      wait_done(0, ok);
      checks++;
      if (!ok || a_count !== 9'd1 || a_busy !== 1'b0) begin
         errors++;
         $display("FAIL add_final got done=%b count=%0d busy=%b want done=1 count=1 busy=0",
                  ok, a_count, a_busy);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      a_got.delete();
      a_cyc.delete();
      exp_q.delete();
      exp_q.push_back({8'd0, 32'h0085_3022});
      exp_q.push_back({8'd1, 32'h00E8_4824});
      pulse_start();
      send_op(0, 2'b10, 5'd4, 5'd5, 5'd6, 1'b0);
      send_op(0, 2'b11, 5'd7, 5'd8, 5'd9, 1'b1);
      wait_done(0, ok);
      checks++;
      if (!ok || a_count !== 9'd2) begin
         errors++;
         $display("FAIL b2b_count got done=%b count=%0d want done=1 count=2", ok, a_count);
      end
      checks++;
      if (a_got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL b2b_nwrites got=%0d want=%0d", a_got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < a_got.size(); i++) begin
         checks++;
         if (a_got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_word%0d got=%h want=%h", i, a_got[i], exp_q[i]);
         end
      end
`ifndef LOADER_READBACK_EN
      if (a_cyc.size() == 2) begin
         checks++;
         if (a_cyc[1] - a_cyc[0] != 1) begin
            errors++;
            $display("FAIL b2b_spacing got=%0d want=1", a_cyc[1] - a_cyc[0]);
         end
      end
`endif
   endtask

   task automatic test_nop();
      bit ok;
      a_got.delete();
      pulse_start();
      send_op(0, 2'b00, 5'd31, 5'd31, 5'd31, 1'b1);
      wait_done(0, ok);
      checks++;
      if (!ok || a_got.size() != 1) begin
         errors++;
         $display("FAIL nop_nwrites got done=%b n=%0d want done=1 n=1", ok, a_got.size());
      end else begin
         checks++;
         if (a_got[0] !== 40'h00_0000_0000) begin
            errors++;
            $display("FAIL nop_word got=%h want=0000000000", a_got[0]);
         end
      end
   endtask

   // 4-word imem, ops without last; a mid-load start must be ignored
   task automatic test_full();
      bit ok;
      int ready_seen;
      b_got.delete();
      exp_q.delete();
      exp_q.push_back({6'b0, 2'd0, 32'h0021_0820});
      exp_q.push_back({6'b0, 2'd1, 32'h0042_1022});
      exp_q.push_back({6'b0, 2'd2, 32'h0063_1824});
      exp_q.push_back({6'b0, 2'd3, 32'h0000_0000});
      pulse_start();
      send_op(1, 2'b01, 5'd1, 5'd1, 5'd1, 1'b0);
      send_op(1, 2'b10, 5'd2, 5'd2, 5'd2, 1'b0);
      pulse_start();
      send_op(1, 2'b11, 5'd3, 5'd3, 5'd3, 1'b0);
      send_op(1, 2'b00, 5'd4, 5'd4, 5'd4, 1'b0);
      op_kind = 2'b01; op_rs = 5'd5; op_rt = 5'd5; op_rd = 5'd5; op_last = 1'b0;
      op_valid = 1'b1;
      ready_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (b_ready) ready_seen++;
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      checks++;
      if (ready_seen != 0) begin
         errors++;
         $display("FAIL full_5th_refused got=%0d ready cycles want=0", ready_seen);
      end
      wait_done(1, ok);
      checks++;
      if (!ok || b_full !== 1'b1 || b_count !== 3'd4) begin
         errors++;
         $display("FAIL full_status got done=%b full=%b count=%0d want done=1 full=1 count=4",
                  ok, b_full, b_count);
      end
      checks++;
      if (b_got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL full_nwrites got=%0d want=%0d", b_got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < b_got.size(); i++) begin
         checks++;
         if (b_got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL full_word%0d got=%h want=%h", i, b_got[i], exp_q[i]);
         end
      end
      // start from DONE clears full, done and count
      pulse_start();
      @(negedge clk);
      checks++;
      if ({b_full, b_done} !== 2'b00 || b_count !== 3'd0 || b_state !== 3'd1) begin
         errors++;
         $display("FAIL full_restart got full=%b done=%b count=%0d st=%0d want 0 0 0 1",
                  b_full, b_done, b_count, b_state);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      seen = 1'b0;
      op_kind = 2'b01; op_rs = 5'd6; op_rt = 5'd6; op_rd = 5'd6; op_last = 1'b0;
      op_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (a_we) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL mid_write_seen got=0 want=1");
      end
      #2;
      rst_n = 1'b0;
      op_valid = 1'b0;
      #1;
      checks++;
      if (a_we !== 1'b0 || b_we !== 1'b0) begin
         errors++;
         $display("FAIL mid_we_async got=%b%b want=00", a_we, b_we);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (a_state !== 3'd0 || a_count !== 9'd0 || a_busy !== 1'b0 || a_full !== 1'b0) begin
         errors++;
         $display("FAIL mid_after got st=%0d count=%0d busy=%b full=%b want 0 0 0 0",
                  a_state, a_count, a_busy, a_full);
      end
   endtask

`ifdef LOADER_READBACK_EN
   task automatic test_readback();
      bit ok;
      pulse_start();
      a_acc.delete();
      send_op(0, 2'b01, 5'd1, 5'd2, 5'd3, 1'b0);
      send_op(0, 2'b10, 5'd4, 5'd5, 5'd6, 1'b0);
      send_op(0, 2'b11, 5'd7, 5'd8, 5'd9, 1'b1);
      wait_done(0, ok);
      checks++;
      if (!ok || a_mis !== 1'b1) begin
         errors++;
         $display("FAIL rb_mismatch got done=%b mis=%b want 1 1", ok, a_mis);
      end
      checks++;
      if (a_acc.size() != 3) begin
         errors++;
         $display("FAIL rb_naccept got=%0d want=3", a_acc.size());
      end else begin
         checks++;
         if (a_acc[1] - a_acc[0] != 3 || a_acc[2] - a_acc[1] != 3) begin
            errors++;
            $display("FAIL rb_spacing got=%0d,%0d want=3,3",
                     a_acc[1] - a_acc[0], a_acc[2] - a_acc[1]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_nop();
`ifdef LOADER_READBACK_EN
      test_readback();
`endif
      test_full();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
